// File: rtl/instruction_decoder.sv
// Registered instruction decoder: slices the fetched 32-bit word into fields and
// derives ALU / register-file / PC control, all presented one cycle later.
module instruction_decoder (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    output logic [7:0]  OPCODE,
    output logic [2:0]  REGISTER_DEST,
    output logic [2:0]  REGISTER_1,
    output logic [2:0]  REGISTER_2,
    output logic [4:0]  SH_AMT,
    output logic [5:0]  FUNC,
    output logic [7:0]  IMMIDIATE,
    output logic [25:0] ADDRESS,
    output logic [2:0]  ALUOP,
    output logic        IMM_SEL,
    output logic        SUB_SEL,
    output logic        REG_WRITE_EN,
    output logic        JUMP,
    output logic        BRANCH,
    output logic        INVALID
);

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;

    logic [7:0] opcode_in;
    logic [2:0] aluop_d;
    logic       imm_sel_d;
    logic       sub_sel_d;
    logic       reg_write_en_d;
    logic       jump_d;
    logic       branch_d;
    logic       invalid_d;

    assign opcode_in = INSTRUCTION[31:24];

    always_comb begin
        aluop_d        = ALU_PASS;
        imm_sel_d      = 1'b0;
        sub_sel_d      = 1'b0;
        reg_write_en_d = 1'b0;
        jump_d         = 1'b0;
        branch_d       = 1'b0;
        invalid_d      = 1'b0;
        case (opcode_in)
            OP_LOADI: begin
                imm_sel_d      = 1'b1;
                reg_write_en_d = 1'b1;
            end
            OP_MOV: reg_write_en_d = 1'b1;
            OP_ADD: begin
                aluop_d        = ALU_ADD;
                reg_write_en_d = 1'b1;
            end
            OP_SUB: begin
                aluop_d        = ALU_ADD;
                sub_sel_d      = 1'b1;
                reg_write_en_d = 1'b1;
            end
            OP_AND: begin
                aluop_d        = ALU_AND;
                reg_write_en_d = 1'b1;
            end
            OP_OR: begin
                aluop_d        = ALU_OR;
                reg_write_en_d = 1'b1;
            end
            OP_J: jump_d = 1'b1;
            // beq compares by subtracting, so it reuses the adder with negation
            OP_BEQ: begin
                aluop_d   = ALU_ADD;
                sub_sel_d = 1'b1;
                branch_d  = 1'b1;
            end
            default: invalid_d = 1'b1;
        endcase
    end

    // Reset clears write enable too, so the all-zero word is not taken as loadi
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            OPCODE        <= '0;
            REGISTER_DEST <= '0;
            REGISTER_1    <= '0;
            REGISTER_2    <= '0;
            SH_AMT        <= '0;
            FUNC          <= '0;
            IMMIDIATE     <= '0;
            ADDRESS       <= '0;
            ALUOP         <= '0;
            IMM_SEL       <= 1'b0;
            SUB_SEL       <= 1'b0;
            REG_WRITE_EN  <= 1'b0;
            JUMP          <= 1'b0;
            BRANCH        <= 1'b0;
            INVALID       <= 1'b0;
        end else begin
            OPCODE        <= opcode_in;
            REGISTER_DEST <= INSTRUCTION[18:16];
            REGISTER_1    <= INSTRUCTION[10:8];
            REGISTER_2    <= INSTRUCTION[2:0];
            SH_AMT        <= INSTRUCTION[10:6];
            FUNC          <= INSTRUCTION[5:0];
            IMMIDIATE     <= INSTRUCTION[7:0];
            ADDRESS       <= INSTRUCTION[25:0];
            ALUOP         <= aluop_d;
            IMM_SEL       <= imm_sel_d;
            SUB_SEL       <= sub_sel_d;
            REG_WRITE_EN  <= reg_write_en_d;
            JUMP          <= jump_d;
            BRANCH        <= branch_d;
            INVALID       <= invalid_d;
        end
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: directed test-plan steps followed by random
// words with occasional resets, checked against an arithmetic reference model.
module tb_instruction_decoder;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic [7:0]  OPCODE;
    logic [2:0]  REGISTER_DEST;
    logic [2:0]  REGISTER_1;
    logic [2:0]  REGISTER_2;
    logic [4:0]  SH_AMT;
    logic [5:0]  FUNC;
    logic [7:0]  IMMIDIATE;
    logic [25:0] ADDRESS;
    logic [2:0]  ALUOP;
    logic        IMM_SEL;
    logic        SUB_SEL;
    logic        REG_WRITE_EN;
    logic        JUMP;
    logic        BRANCH;
    logic        INVALID;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected outputs: fields {op,dest,r1,r2,sh,func,imm,addr}, controls {aluop,imm,sub,we,j,br,inv}
    logic [61:0] exp_f;
    logic [8:0]  exp_c;

    instruction_decoder dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .INSTRUCTION  (INSTRUCTION),
        .OPCODE       (OPCODE),
        .REGISTER_DEST(REGISTER_DEST),
        .REGISTER_1   (REGISTER_1),
        .REGISTER_2   (REGISTER_2),
        .SH_AMT       (SH_AMT),
        .FUNC         (FUNC),
        .IMMIDIATE    (IMMIDIATE),
        .ADDRESS      (ADDRESS),
        .ALUOP        (ALUOP),
        .IMM_SEL      (IMM_SEL),
        .SUB_SEL      (SUB_SEL),
        .REG_WRITE_EN (REG_WRITE_EN),
        .JUMP         (JUMP),
        .BRANCH       (BRANCH),
        .INVALID      (INVALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [61:0] obs_fields();
        return {OPCODE, REGISTER_DEST, REGISTER_1, REGISTER_2, SH_AMT, FUNC, IMMIDIATE, ADDRESS};
    endfunction

    function automatic logic [8:0] obs_ctrl();
        return {ALUOP, IMM_SEL, SUB_SEL, REG_WRITE_EN, JUMP, BRANCH, INVALID};
    endfunction

    // Reference model: fields by shift/modulo, controls from the opcode table
    task automatic model(input logic rst, input logic [31:0] w);
        int op, dest, r1, r2, sh, fn, imm, adr, alu;
        int alu_tbl [8] = '{0, 0, 1, 1, 2, 3, 0, 1};
        if (!rst) begin
            exp_f = '0;
            exp_c = '0;
        end else begin
            op   = int'(w >> 24);
            dest = int'((w >> 16) % 8);
            r1   = int'((w >> 8) % 8);
            r2   = int'(w % 8);
            sh   = int'((w >> 6) % 32);
            fn   = int'(w % 64);
            imm  = int'(w % 256);
            adr  = int'(w % (32'd1 << 26));
            alu  = (op < 8) ? alu_tbl[op] : 0;
            exp_f = {op[7:0], dest[2:0], r1[2:0], r2[2:0], sh[4:0], fn[5:0], imm[7:0], adr[25:0]};
            exp_c = {alu[2:0], 1'(op == 0), 1'(op == 3 || op == 7), 1'(op <= 5),
                     1'(op == 6), 1'(op == 7), 1'(op > 7)};
        end
    endtask

    task automatic check(input string tag);
        n_assert++;
        assert (obs_fields() === exp_f) else begin
            n_fail++;
            $error("FAIL %s fields: observed %h expected %h", tag, obs_fields(), exp_f);
        end
        n_assert++;
        assert (obs_ctrl() === exp_c) else begin
            n_fail++;
            $error("FAIL %s ctrl: observed %b expected %b", tag, obs_ctrl(), exp_c);
        end
    endtask

    // One edge: drive at negedge, check after the edge, then disturb the
    // input mid-cycle and confirm the outputs hold.
    task automatic step(input logic rst, input logic [31:0] w, input string tag);
        @(negedge CLK);
        RESET       = rst;
        INSTRUCTION = w;
        @(posedge CLK);
        model(rst, w);
        #1;
        check(tag);
        INSTRUCTION = $urandom;
        #2;
        check({tag, "_hold"});
    endtask

    task automatic check_bit(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic        r;
        RESET       = 1'b0;
        INSTRUCTION = 32'h0;

        step(1'b0, 32'h02060402, "reset1");
        step(1'b0, 32'h02060402, "reset2");
        check_bit("reset_we", 32'(REG_WRITE_EN), 32'h0);

        step(1'b1, 32'h00040005, "loadi");
        check_bit("loadi_addr", 32'(ADDRESS), 32'h0040005);
        check_bit("loadi_immsel_we", {30'h0, IMM_SEL, REG_WRITE_EN}, 32'h3);
        check_bit("loadi_imm", 32'(IMMIDIATE), 32'h05);

        step(1'b1, 32'h02060402, "add");
        check_bit("add_regs", {20'h0, REGISTER_DEST, REGISTER_1, REGISTER_2, ALUOP}, {20'h0, 3'd6, 3'd4, 3'd2, 3'b001});
        step(1'b1, 32'h01000006, "mov");
        check_bit("mov_r2", 32'(REGISTER_2), 32'h6);

        step(1'b1, 32'h020207C1, "overlap_add");
        check_bit("overlap_fields", {9'h0, REGISTER_1, SH_AMT, FUNC, REGISTER_2, IMMIDIATE},
                  {9'h0, 3'd7, 5'h1F, 6'h01, 3'd1, 8'hC1});
        step(1'b1, 32'h030207C1, "overlap_sub");
        check_bit("sub_ctrl", {28'h0, SUB_SEL, ALUOP}, {28'h0, 1'b1, 3'b001});

        step(1'b1, 32'hFF123456, "invalid");
        check_bit("invalid_ctrl", 32'(obs_ctrl()), 32'h001);
        step(1'b1, 32'h06ABCDEF, "jump");
        step(1'b1, 32'h07010203, "beq");
        step(1'b1, 32'h08000000, "invalid_lo");

        step(1'b1, 32'h02060402, "pre_mid_reset");
        step(1'b0, 32'h02020201, "mid_reset");
        step(1'b1, 32'h02020201, "after_reset");

        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 15) != 0);
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[31:24] = 8'($urandom_range(0, 9));
            step(r, w, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
